// File: rtl/timer_svc_pkg.sv
// Shared types and constants for the interval-timer service master.
// Pure declarations: no logic, no latency.
// Not applicable: no handshakes live in this package.
//
// Contents:
//   state_t    - service FSM states
//   cmd_op_t   - command opcodes on cmd_op
//   cfg_t      - CONFIG_START parameters captured when a command is accepted
//   REG_*      - timer-slave register indices (0..5)
//   CTRL_*     - bit positions inside the control register
//   ctrl_word  - builds a control-register write value from individual bits
package timer_svc_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    CFG_STOP = 4'd1,
    CFG_PL   = 4'd2,
    CFG_PH   = 4'd3,
    CFG_CLR  = 4'd4,
    CFG_GO   = 4'd5,
    STOP_W   = 4'd6,
    SNAP_W   = 4'd7,
    SNAP_RL  = 4'd8,
    SNAP_RH  = 4'd9,
    SNAP_CAP = 4'd10,
    IRQ_CLR  = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    OP_CONFIG_START = 2'd0,
    OP_STOP         = 2'd1,
    OP_SNAPSHOT     = 2'd2,
    OP_RESERVED     = 2'd3
  } cmd_op_t;

  typedef struct packed {
    logic [31:0] period;
    logic        cont;
    logic        ito;
  } cfg_t;

  // Timer-slave register map
  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_CONTROL = 3'd1;
  localparam logic [2:0] REG_PERIODL = 3'd2;
  localparam logic [2:0] REG_PERIODH = 3'd3;
  localparam logic [2:0] REG_SNAPL   = 3'd4;
  localparam logic [2:0] REG_SNAPH   = 3'd5;

  // Control register bit positions
  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  function automatic logic [15:0] ctrl_word(input logic stop,
                                            input logic start,
                                            input logic cont,
                                            input logic ito);
    logic [15:0] w;
    w             = '0;
    w[CTRL_STOP]  = stop;
    w[CTRL_START] = start;
    w[CTRL_CONT]  = cont;
    w[CTRL_ITO]   = ito;
    return w;
  endfunction

endpackage

// File: rtl/timer_svc_master.sv
// Sequences timer-slave bus accesses for config/stop/snapshot commands and services the timer irq.
// Latency: first bus cycle one cycle after accept; CONFIG 5 cycles, STOP 1, SNAPSHOT snap_valid 5 after accept.
// Backpressure: cmd_ready only in IDLE with irq_in low; a pending irq is always serviced before a command.
//
// Ports:
//   clk, reset          - single clock, synchronous active-high reset
//   cmd_valid/cmd_ready - command handshake; cmd_op selects CONFIG_START/STOP/SNAPSHOT/reserved
//   cmd_period/cont/ito - CONFIG_START parameters, captured on accept
//   avm_*               - timer-slave bus (no waitrequest; read data arrives one cycle after address)
//   irq_in              - level timeout interrupt from the timer slave
//   snap_valid/value    - one-cycle pulse with the 32-bit snapshot; value holds until the next snapshot
//   tick/tick_count     - one-cycle pulse and wrapping count per serviced interrupt
//   busy                - a sequence (or irq service) is in progress
module timer_svc_master
  import timer_svc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,

  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_period,
  input  logic        cmd_cont,
  input  logic        cmd_ito,

  output logic [2:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [15:0] avm_writedata,
  input  logic [15:0] avm_readdata,
  input  logic        irq_in,

  output logic        snap_valid,
  output logic [31:0] snap_value,
  output logic        tick,
  output logic [15:0] tick_count,
  output logic        busy
);

  state_t      state_q,      state_d;
  cfg_t        cfg_q,        cfg_d;
  logic [31:0] snap_value_q, snap_value_d;
  logic        snap_valid_q, snap_valid_d;
  logic [15:0] tick_count_q, tick_count_d;

  logic        in_idle;

  assign in_idle   = (state_q == IDLE);
  assign cmd_ready = in_idle && !irq_in;
  assign busy      = !in_idle;

  // ---------------------------------------------------------------------------
  // Next-state and datapath updates
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    snap_value_d = snap_value_q;
    snap_valid_d = 1'b0;
    tick_count_d = tick_count_q;

    case (state_q)
      IDLE: begin
        // irq wins over a waiting command; cmd_ready is already low here
        if (irq_in) begin
          state_d = IRQ_CLR;
        end else if (cmd_valid) begin
          cfg_d = '{period: cmd_period, cont: cmd_cont, ito: cmd_ito};
          case (cmd_op_t'(cmd_op))
            OP_CONFIG_START: state_d = CFG_STOP;
            OP_STOP:         state_d = STOP_W;
            OP_SNAPSHOT:     state_d = SNAP_W;
            default:         state_d = IDLE;   // reserved: consumed silently
          endcase
        end
      end

      CFG_STOP: state_d = CFG_PL;
      CFG_PL:   state_d = CFG_PH;
      CFG_PH:   state_d = CFG_CLR;
      CFG_CLR:  state_d = CFG_GO;
      CFG_GO:   state_d = IDLE;

      STOP_W:   state_d = IDLE;

      SNAP_W:   state_d = SNAP_RL;
      SNAP_RL:  state_d = SNAP_RH;
      SNAP_RH: begin
        // readdata now carries the SNAPL address presented in SNAP_RL
        snap_value_d[15:0] = avm_readdata;
        state_d            = SNAP_CAP;
      end
      SNAP_CAP: begin
        // readdata now carries the SNAPH address presented in SNAP_RH
        snap_value_d[31:16] = avm_readdata;
        snap_valid_d        = 1'b1;
        state_d             = IDLE;
      end

      IRQ_CLR: begin
        tick_count_d = tick_count_q + 16'd1;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Moore bus decode: depends only on the state register and captured config
  // ---------------------------------------------------------------------------
  always_comb begin
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_writedata  = 16'h0000;
    avm_address    = REG_STATUS;
    tick           = 1'b0;

    case (state_q)
      CFG_STOP, STOP_W: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_CONTROL;
        avm_writedata  = ctrl_word(1'b1, 1'b0, 1'b0, 1'b0);
      end
      CFG_PL: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_PERIODL;
        avm_writedata  = cfg_q.period[15:0];
      end
      CFG_PH: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_PERIODH;
        avm_writedata  = cfg_q.period[31:16];
      end
      CFG_CLR: begin
        // clears any timeout left over from the previous run
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_STATUS;
      end
      CFG_GO: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_CONTROL;
        avm_writedata  = ctrl_word(1'b0, 1'b1, cfg_q.cont, cfg_q.ito);
      end
      SNAP_W: begin
        // any write to SNAPL latches the live counter into the snap registers
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_SNAPL;
      end
      SNAP_RL: avm_address = REG_SNAPL;
      SNAP_RH, SNAP_CAP: avm_address = REG_SNAPH;
      IRQ_CLR: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = REG_STATUS;
        tick           = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cfg_q        <= '0;
      snap_value_q <= '0;
      snap_valid_q <= 1'b0;
      tick_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      snap_value_q <= snap_value_d;
      snap_valid_q <= snap_valid_d;
      tick_count_q <= tick_count_d;
    end
  end

  assign snap_valid = snap_valid_q;
  assign snap_value = snap_value_q;
  assign tick_count = tick_count_q;

endmodule

// File: tb/tb_timer_svc_master.sv
module tb_timer_svc_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [31:0] cmd_period = 32'd0;
  logic        cmd_cont = 1'b0;
  logic        cmd_ito = 1'b0;
  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata;
  logic        irq_in = 1'b0;
  logic        snap_valid;
  logic [31:0] snap_value;
  logic        tick;
  logic [15:0] tick_count;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  timer_svc_master dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_period(cmd_period), .cmd_cont(cmd_cont), .cmd_ito(cmd_ito),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .irq_in(irq_in),
    .snap_valid(snap_valid), .snap_value(snap_value),
    .tick(tick), .tick_count(tick_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- timer slave model ----------------
  logic [15:0] tregs [0:7];
  logic [31:0] snap_latch;
  logic [31:0] tmr_counter = 32'd0;

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 8; k++) tregs[k] <= 16'h0;
      snap_latch   <= 32'h0;
      avm_readdata <= 16'h0;
    end else begin
      if (avm_chipselect && !avm_write_n) begin
        if (avm_address == 3'd4) snap_latch <= tmr_counter;
        else tregs[avm_address] <= avm_writedata;
      end
      if (avm_address == 3'd4)      avm_readdata <= snap_latch[15:0];
      else if (avm_address == 3'd5) avm_readdata <= snap_latch[31:16];
      else                          avm_readdata <= tregs[avm_address];
    end
  end

  // ---------------- bus / event monitor ----------------
  typedef struct { int c; logic [2:0] a; logic [15:0] d; } wr_t;
  typedef struct { int c; logic [31:0] v; } sv_t;
  typedef struct { logic [2:0] a; logic [15:0] d; } ew_t;
  wr_t wr_q[$];
  sv_t sv_q[$];
  ew_t exp_q[$];

  always @(posedge clk) begin
    if (!reset && avm_chipselect && !avm_write_n) wr_q.push_back('{cyc, avm_address, avm_writedata});
    if (!reset && snap_valid) sv_q.push_back('{cyc, snap_value});
    cyc <= cyc + 1;
  end

  // ---------------- reference model state ----------------
  logic [15:0] exp_ticks = 16'h0;
  logic [31:0] last_snap = 32'h0;

  // Expected bus writes of one command, straight from the command rules
  task automatic build_expected(input logic [1:0] op, input logic [31:0] per,
                                input logic c, input logic i);
    exp_q.delete();
    case (op)
      2'd0: begin
        exp_q.push_back('{3'd1, 16'h0008});
        exp_q.push_back('{3'd2, 16'(per % 32'd65536)});
        exp_q.push_back('{3'd3, 16'(per / 32'd65536)});
        exp_q.push_back('{3'd0, 16'h0000});
        exp_q.push_back('{3'd1, 16'(4 + 2 * int'(c) + int'(i))});
      end
      2'd1: exp_q.push_back('{3'd1, 16'h0008});
      2'd2: exp_q.push_back('{3'd4, 16'h0000});
      default: ;
    endcase
  endtask

  // Present a command at a negedge; returns at the negedge of the first bus cycle
  task automatic send_cmd(input logic [1:0] op, input logic [31:0] per,
                          input logic c, input logic i, output int acc, output bit ok);
    ok  = 1'b0;
    acc = -1;
    cmd_valid = 1'b1; cmd_op = op; cmd_period = per; cmd_cont = c; cmd_ito = i;
    #1;
    for (int n = 0; n < 50; n++) begin
      if (cmd_ready) begin acc = cyc; ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    @(negedge clk);
    cmd_valid  = 1'b0;
    cmd_op     = 2'($urandom_range(0, 3));
    cmd_period = $urandom;
    cmd_cont   = 1'($urandom_range(0, 1));
    cmd_ito    = 1'($urandom_range(0, 1));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (avm_chipselect !== 1'b0) begin n_fail++; $display("FAIL reset_cs: got %b want 0", avm_chipselect); end
    n_cmp++; if (avm_write_n !== 1'b1) begin n_fail++; $display("FAIL reset_write_n: got %b want 1", avm_write_n); end
    n_cmp++; if (avm_address !== 3'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", avm_address); end
    n_cmp++; if (avm_writedata !== 16'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0000", avm_writedata); end
    n_cmp++; if (snap_valid !== 1'b0 || tick !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got snap_valid=%b tick=%b want 0 0", snap_valid, tick); end
    n_cmp++; if (snap_value !== 32'h0) begin n_fail++; $display("FAIL reset_snap_value: got %h want 0", snap_value); end
    n_cmp++; if (tick_count !== 16'h0) begin n_fail++; $display("FAIL reset_tick_count: got %h want 0", tick_count); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_config_fixed();
    logic [2:0]  ea [0:4];
    logic [15:0] ed [0:4];
    int acc; bit ok;
    ea = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd1};
    ed = '{16'h0008, 16'h86A0, 16'h0001, 16'h0000, 16'h0007};
    send_cmd(2'd0, 32'h0001_86A0, 1'b1, 1'b1, acc, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL cfg_accept: got not-accepted want accepted"); end
    for (int j = 0; j < 5; j++) begin
      n_cmp++;
      if ({avm_chipselect, avm_write_n, avm_address, avm_writedata} !== {1'b1, 1'b0, ea[j], ed[j]}) begin
        n_fail++;
        $display("FAIL cfg_write%0d: got cs=%b wn=%b %0d:%h want cs=1 wn=0 %0d:%h",
                 j, avm_chipselect, avm_write_n, avm_address, avm_writedata, ea[j], ed[j]);
      end
      @(negedge clk);
    end
    n_cmp++; if (busy !== 1'b0 || avm_chipselect !== 1'b0) begin n_fail++; $display("FAIL cfg_done: got busy=%b cs=%b want 0 0", busy, avm_chipselect); end
    n_cmp++; if ({tregs[1], tregs[2], tregs[3]} !== {16'h0007, 16'h86A0, 16'h0001}) begin
      n_fail++; $display("FAIL cfg_slave_regs: got ctl=%h pl=%h ph=%h want 0007 86a0 0001", tregs[1], tregs[2], tregs[3]);
    end
  endtask

  task automatic test_stop();
    int acc; bit ok;
    send_cmd(2'd1, $urandom, 1'b1, 1'b1, acc, ok);
    n_cmp++;
    if (!ok || {avm_chipselect, avm_write_n, avm_address, avm_writedata} !== {1'b1, 1'b0, 3'd1, 16'h0008}) begin
      n_fail++; $display("FAIL stop_write: got ok=%b cs=%b wn=%b %0d:%h want 1 1 0 1:0008", ok, avm_chipselect, avm_write_n, avm_address, avm_writedata);
    end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || avm_chipselect !== 1'b0) begin n_fail++; $display("FAIL stop_single: got busy=%b cs=%b want 0 0", busy, avm_chipselect); end
  endtask

  task automatic test_irq();
    irq_in = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({avm_chipselect, avm_write_n, avm_address, avm_writedata, tick} !== {1'b1, 1'b0, 3'd0, 16'h0, 1'b1}) begin
      n_fail++; $display("FAIL irq_service: got cs=%b wn=%b %0d:%h tick=%b want 1 0 0:0000 1", avm_chipselect, avm_write_n, avm_address, avm_writedata, tick);
    end
    irq_in = 1'b0;
    exp_ticks = exp_ticks + 16'd1;
    @(negedge clk);
    n_cmp++; if (tick !== 1'b0 || tick_count !== exp_ticks) begin n_fail++; $display("FAIL irq_count: got tick=%b count=%h want 0 %h", tick, tick_count, exp_ticks); end
    wr_q.delete();
    repeat (5) @(negedge clk);
    n_cmp++; if (wr_q.size() != 0 || tick_count !== exp_ticks) begin n_fail++; $display("FAIL irq_no_repeat: got writes=%0d count=%h want 0 %h", wr_q.size(), tick_count, exp_ticks); end
  endtask

  task automatic test_snapshot_fixed();
    int acc; bit ok;
    tmr_counter = 32'h0012_3456;
    sv_q.delete();
    send_cmd(2'd2, $urandom, 1'b0, 1'b0, acc, ok);
    repeat (6) @(negedge clk);
    n_cmp++; if (!ok || sv_q.size() != 1) begin n_fail++; $display("FAIL snap_pulse_count: got ok=%b pulses=%0d want 1 1", ok, sv_q.size()); end
    n_cmp++;
    if (sv_q.size() < 1 || sv_q[0].c != acc + 5 || sv_q[0].v !== 32'h0012_3456) begin
      n_fail++; $display("FAIL snap_pulse: got cycle_offset=%0d value=%h want 5 00123456",
                         (sv_q.size() > 0) ? sv_q[0].c - acc : -1, (sv_q.size() > 0) ? sv_q[0].v : 32'hx);
    end
    n_cmp++; if (snap_value !== 32'h0012_3456 || snap_valid !== 1'b0) begin n_fail++; $display("FAIL snap_hold: got value=%h valid=%b want 00123456 0", snap_value, snap_valid); end
    last_snap = 32'h0012_3456;
  endtask

  task automatic test_irq_vs_cmd();
    irq_in = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd1; cmd_period = $urandom;
    #1;
    n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL prio_ready: got %b want 0", cmd_ready); end
    @(negedge clk);
    n_cmp++;
    if ({tick, avm_chipselect, avm_write_n, avm_address, cmd_ready} !== {1'b1, 1'b1, 1'b0, 3'd0, 1'b0}) begin
      n_fail++; $display("FAIL prio_irq_first: got tick=%b cs=%b wn=%b addr=%0d ready=%b want 1 1 0 0 0", tick, avm_chipselect, avm_write_n, avm_address, cmd_ready);
    end
    irq_in = 1'b0;
    exp_ticks = exp_ticks + 16'd1;
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL prio_ready_after: got %b want 1", cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0;
    n_cmp++;
    if ({avm_chipselect, avm_write_n, avm_address, avm_writedata} !== {1'b1, 1'b0, 3'd1, 16'h0008}) begin
      n_fail++; $display("FAIL prio_cmd_next: got cs=%b wn=%b %0d:%h want 1 0 1:0008", avm_chipselect, avm_write_n, avm_address, avm_writedata);
    end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || tick_count !== exp_ticks) begin n_fail++; $display("FAIL prio_end: got busy=%b count=%h want 0 %h", busy, tick_count, exp_ticks); end
  endtask

  task automatic test_irq_during_seq();
    int acc; bit ok; bit served;
    logic [31:0] per;
    logic c, i;
    per = $urandom; c = 1'($urandom_range(0, 1)); i = 1'($urandom_range(0, 1));
    build_expected(2'd0, per, c, i);
    wr_q.delete();
    served = 1'b0;
    send_cmd(2'd0, per, c, i, acc, ok);
    irq_in = 1'b1;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (avm_chipselect && !avm_write_n && tick) begin served = 1'b1; irq_in = 1'b0; break; end
    end
    irq_in = 1'b0;
    exp_ticks = exp_ticks + 16'd1;
    exp_q.push_back('{3'd0, 16'h0000});
    @(negedge clk);
    n_cmp++; if (!served || wr_q.size() != 6) begin n_fail++; $display("FAIL seq_irq_count: got served=%b writes=%0d want 1 6", served, wr_q.size()); end
    for (int j = 0; j < 6 && j < wr_q.size(); j++) begin
      n_cmp++;
      if (wr_q[j].c != acc + 1 + j + ((j == 5) ? 1 : 0) || wr_q[j].a !== exp_q[j].a || wr_q[j].d !== exp_q[j].d) begin
        n_fail++; $display("FAIL seq_irq_write%0d: got +%0d %0d:%h want +%0d %0d:%h", j, wr_q[j].c - acc, wr_q[j].a, wr_q[j].d,
                           1 + j + ((j == 5) ? 1 : 0), exp_q[j].a, exp_q[j].d);
      end
    end
    n_cmp++; if (tick_count !== exp_ticks) begin n_fail++; $display("FAIL seq_irq_ticks: got %h want %h", tick_count, exp_ticks); end
  endtask

  task automatic test_random();
    int acc; bit ok; bit seen; int sel;
    logic [1:0] op; logic [31:0] per; logic c, i;
    for (int k = 0; k < 40; k++) begin
      sel = (k < 4) ? k : $urandom_range(0, 4);
      if (sel == 4) begin
        irq_in = 1'b1; seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
          @(negedge clk);
          if (avm_chipselect && !avm_write_n && tick && avm_address == 3'd0) begin seen = 1'b1; break; end
        end
        irq_in = 1'b0;
        exp_ticks = exp_ticks + 16'd1;
        @(negedge clk);
        n_cmp++; if (!seen || tick_count !== exp_ticks) begin n_fail++; $display("FAIL rnd_irq%0d: got seen=%b count=%h want 1 %h", k, seen, tick_count, exp_ticks); end
      end else begin
        op = 2'(sel); per = $urandom; c = 1'($urandom_range(0, 1)); i = 1'($urandom_range(0, 1));
        if (op == 2'd2) tmr_counter = $urandom;
        build_expected(op, per, c, i);
        wr_q.delete(); sv_q.delete();
        send_cmd(op, per, c, i, acc, ok);
        for (int n = 0; n < 20; n++) begin
          if (!busy) break;
          @(negedge clk);
        end
        n_cmp++; if (!ok || busy !== 1'b0) begin n_fail++; $display("FAIL rnd_done%0d: got ok=%b busy=%b want 1 0", k, ok, busy); end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (wr_q.size() != exp_q.size()) begin
          n_fail++; $display("FAIL rnd_nwrites%0d op%0d: got %0d want %0d", k, op, wr_q.size(), exp_q.size());
        end else begin
          for (int j = 0; j < exp_q.size(); j++) begin
            n_cmp++;
            if (wr_q[j].c != acc + 1 + j || wr_q[j].a !== exp_q[j].a || wr_q[j].d !== exp_q[j].d) begin
              n_fail++; $display("FAIL rnd_write%0d_%0d: got +%0d %0d:%h want +%0d %0d:%h", k, j,
                                 wr_q[j].c - acc, wr_q[j].a, wr_q[j].d, 1 + j, exp_q[j].a, exp_q[j].d);
            end
          end
        end
        if (op == 2'd2) last_snap = tmr_counter;
        n_cmp++;
        if (sv_q.size() != ((op == 2'd2) ? 1 : 0) ||
            (sv_q.size() == 1 && (sv_q[0].c != acc + 5 || sv_q[0].v !== last_snap))) begin
          n_fail++; $display("FAIL rnd_snap%0d: got pulses=%0d want %0d value %h", k, sv_q.size(), (op == 2'd2) ? 1 : 0, last_snap);
        end
        n_cmp++; if (snap_value !== last_snap) begin n_fail++; $display("FAIL rnd_snap_hold%0d: got %h want %h", k, snap_value, last_snap); end
      end
    end
  endtask

  task automatic test_wrap();
    force dut.tick_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.tick_count_q;
    exp_ticks = 16'hFFFF;
    irq_in = 1'b1;
    @(negedge clk);
    n_cmp++; if (tick !== 1'b1) begin n_fail++; $display("FAIL wrap_tick: got %b want 1", tick); end
    irq_in = 1'b0;
    exp_ticks = exp_ticks + 16'd1;
    @(negedge clk);
    n_cmp++; if (tick_count !== exp_ticks) begin n_fail++; $display("FAIL wrap_count: got %h want %h", tick_count, exp_ticks); end
  endtask

  task automatic test_reset_mid();
    int acc; bit ok;
    send_cmd(2'd0, $urandom, 1'b1, 1'b0, acc, ok);
    repeat (2) @(negedge clk);
    n_cmp++; if (!ok || avm_address !== 3'd3 || avm_chipselect !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ph: got ok=%b addr=%0d cs=%b want 1 3 1", ok, avm_address, avm_chipselect); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (avm_chipselect !== 1'b0 || busy !== 1'b0 || avm_write_n !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_abort: got cs=%b busy=%b wn=%b want 0 0 1", avm_chipselect, busy, avm_write_n);
    end
    reset = 1'b0;
    exp_ticks = 16'h0; last_snap = 32'h0;
    wr_q.delete();
    repeat (8) @(negedge clk);
    n_cmp++; if (wr_q.size() != 0) begin n_fail++; $display("FAIL rstmid_no_writes: got %0d want 0", wr_q.size()); end
    n_cmp++; if (tick_count !== exp_ticks || snap_value !== last_snap) begin n_fail++; $display("FAIL rstmid_state: got count=%h snap=%h want %h %h", tick_count, snap_value, exp_ticks, last_snap); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_config_fixed();
    test_stop();
    test_irq();
    test_snapshot_fixed();
    test_irq_vs_cmd();
    test_irq_during_seq();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
